// File: rtl/div_pkg.sv
// Shared constants and helpers for the divider operand queue.
// Zero-divisor result is selected in the top by DIVQ_ZERO_SAT_EN.
package div_pkg;

    localparam int DIVQ_DATAWIDTH_DEF = 8;
    localparam int DIVQ_DEPTH_DEF     = 4;

    // Driven to the divider while idle so it never sees a zero divisor.
    localparam int DIVQ_IDLE_DIVISOR = 1;

    // Wide enough for any practical DATAWIDTH; consumers truncate.
    localparam logic [63:0] DIVQ_ZERO_RES_CLR = '0;
    localparam logic [63:0] DIVQ_ZERO_RES_SAT = '1;

    function automatic int divq_clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/divq_fifo.sv
// Operand-pair FIFO: storage, wrapping pointers and occupancy count.
// Push is ignored when full and pop when empty, so callers may drive them loosely.
module divq_fifo
    import div_pkg::*;
#(
    parameter int DATAWIDTH = DIVQ_DATAWIDTH_DEF,
    parameter int DEPTH     = DIVQ_DEPTH_DEF
) (
    input  logic                                Clk,
    input  logic                                Rst,
    input  logic                                push_i,
    input  logic                                pop_i,
    input  logic [DATAWIDTH-1:0]                push_a_i,
    input  logic [DATAWIDTH-1:0]                push_b_i,
    output logic [DATAWIDTH-1:0]                head_a_o,
    output logic [DATAWIDTH-1:0]                head_b_o,
    output logic                                full_o,
    output logic                                empty_o,
    output logic [divq_clog2(DEPTH+1)-1:0]      count_o
);

    localparam int PW = divq_clog2(DEPTH);
    localparam int CW = divq_clog2(DEPTH + 1);

    logic [DATAWIDTH-1:0] mem_a_q [DEPTH];
    logic [DATAWIDTH-1:0] mem_b_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 push_ok, pop_ok;

    assign full_o   = (count_q == CW'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    assign head_a_o = mem_a_q[rd_ptr_q];
    assign head_b_o = mem_b_q[rd_ptr_q];

    // A full queue refuses a push even when a pop happens in the same cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; the pointers define what is valid.
    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem_a_q[wr_ptr_q] <= push_a_i;
            mem_b_q[wr_ptr_q] <= push_b_i;
        end
    end

endmodule

// File: rtl/div_operand_queue.sv
// Operand queue in front of a combinational divider with a registered, zero-screened result.
// Define DIVQ_ZERO_SAT_EN to return all-ones instead of zero for a zero divisor.
module div_operand_queue
    import div_pkg::*;
#(
    parameter int DATAWIDTH = DIVQ_DATAWIDTH_DEF,
    parameter int DEPTH     = DIVQ_DEPTH_DEF
) (
    input  logic                                Clk,
    input  logic                                Rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATAWIDTH-1:0]                in_a,
    input  logic [DATAWIDTH-1:0]                in_b,
    output logic [DATAWIDTH-1:0]                div_a,
    output logic [DATAWIDTH-1:0]                div_b,
    input  logic [DATAWIDTH-1:0]                div_quot,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATAWIDTH-1:0]                out_quot,
    output logic                                out_dz,
    output logic [divq_clog2(DEPTH+1)-1:0]      count
);

    localparam logic [DATAWIDTH-1:0] IDLE_B = DATAWIDTH'(DIVQ_IDLE_DIVISOR);
`ifdef DIVQ_ZERO_SAT_EN
    localparam logic [DATAWIDTH-1:0] ZERO_RES = DATAWIDTH'(DIVQ_ZERO_RES_SAT);
`else
    localparam logic [DATAWIDTH-1:0] ZERO_RES = DATAWIDTH'(DIVQ_ZERO_RES_CLR);
`endif

    logic                 fifo_full, fifo_empty;
    logic [DATAWIDTH-1:0] head_a, head_b;
    logic                 push, pop, slot_free, head_dz;

    logic                 out_valid_q, out_valid_d;
    logic [DATAWIDTH-1:0] out_quot_q, out_quot_d;
    logic                 out_dz_q, out_dz_d;

    assign in_ready  = !fifo_full;
    assign push      = in_valid && !fifo_full;
    assign slot_free = !out_valid_q || out_ready;
    assign pop       = !fifo_empty && slot_free;

    divq_fifo #(
        .DATAWIDTH (DATAWIDTH),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .Clk      (Clk),
        .Rst      (Rst),
        .push_i   (push),
        .pop_i    (pop),
        .push_a_i (in_a),
        .push_b_i (in_b),
        .head_a_o (head_a),
        .head_b_o (head_b),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (count)
    );

    // Idle operands keep the divider away from 0/0 when nothing is queued.
    assign div_a   = fifo_empty ? '0 : head_a;
    assign div_b   = fifo_empty ? IDLE_B : head_b;
    assign head_dz = (head_b == '0);

    always_comb begin
        out_valid_d = out_valid_q;
        out_quot_d  = out_quot_q;
        out_dz_d    = out_dz_q;
        if (pop) begin
            out_valid_d = 1'b1;
            out_quot_d  = head_dz ? ZERO_RES : div_quot;
            out_dz_d    = head_dz;
        end else if (slot_free) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            out_valid_q <= 1'b0;
            out_quot_q  <= '0;
            out_dz_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_quot_q  <= out_quot_d;
            out_dz_q    <= out_dz_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_quot  = out_quot_q;
    assign out_dz    = out_dz_q;

endmodule

// File: tb/tb_div_operand_queue.sv
// Self-checking bench: queue-based reference model plus directed literal checks.
module tb_div_operand_queue;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
`ifdef DIVQ_ZERO_SAT_EN
    localparam logic [DW-1:0] ZR = 8'hFF;
`else
    localparam logic [DW-1:0] ZR = 8'h00;
`endif

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] div_quot;
    logic          in_ready;
    logic [DW-1:0] div_a, div_b;
    logic          out_valid;
    logic [DW-1:0] out_quot;
    logic          out_dz;
    logic [2:0]    count;

    int total = 0;
    int bad   = 0;

    div_operand_queue #(.DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_quot  (div_quot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_quot  (out_quot),
        .out_dz    (out_dz),
        .count     (count)
    );

    always #5 Clk = ~Clk;

    // Stand-in divider; a junk value on zero divisor must never reach out_quot.
    always_comb begin
        div_quot = 8'h5A;
        if (div_b != '0) div_quot = div_a / div_b;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } pair_t;

    pair_t         mq[$];
    bit            m_ov;
    logic [DW-1:0] m_oq;
    bit            m_odz;

    // Reference model: a plain queue plus one output slot.
    always @(posedge Clk or negedge Rst) begin
        bit    do_push, free;
        pair_t p;
        if (!Rst) begin
            mq.delete();
            m_ov  = 0;
            m_oq  = '0;
            m_odz = 0;
        end else begin
            do_push = in_valid && (mq.size() < DEPTH);
            free    = !m_ov || out_ready;
            if (free) begin
                if (mq.size() > 0) begin
                    p     = mq.pop_front();
                    m_ov  = 1;
                    m_odz = (p.b == 0);
                    m_oq  = (p.b == 0) ? ZR : p.a / p.b;
                end else begin
                    m_ov = 0;
                end
            end
            if (do_push) begin
                p.a = in_a;
                p.b = in_b;
                mq.push_back(p);
            end
        end
    end

    always @(negedge Clk) begin
        check("m_count", int'(count), mq.size());
        check("m_in_ready", int'(in_ready), int'(mq.size() != DEPTH));
        check("m_out_valid", int'(out_valid), int'(m_ov));
        check("m_div_a", int'(div_a), (mq.size() > 0) ? int'(mq[0].a) : 0);
        check("m_div_b", int'(div_b), (mq.size() > 0) ? int'(mq[0].b) : 1);
        if (m_ov) begin
            check("m_out_quot", int'(out_quot), int'(m_oq));
            check("m_out_dz", int'(out_dz), int'(m_odz));
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, int'(count), 0);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_quot"}, int'(out_quot), 0);
        check({tag, "_out_dz"}, int'(out_dz), 0);
        check({tag, "_div_a"}, int'(div_a), 0);
        check({tag, "_div_b"}, int'(div_b), 1);
    endtask

    initial begin
        logic [DW-1:0] bp_a [5];
        logic [DW-1:0] bp_b [5];
        logic [DW-1:0] rel [4];
        bp_a = '{8'd10, 8'd9, 8'd8, 8'd7, 8'd6};
        bp_b = '{8'd2, 8'd3, 8'd4, 8'd7, 8'd1};
        rel  = '{8'd3, 8'd2, 8'd1, 8'd6};

        repeat (2) @(posedge Clk);
        #1;
        check_reset_state("rst");
        Rst = 1'b1;
        tick();
        check_reset_state("idle");

        // Single pair, one-cycle latency.
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'd100; in_b = 8'd7;
        tick();
        in_valid = 1'b0;
        check("lat_count1", int'(count), 1);
        check("lat_div_a", int'(div_a), 100);
        check("lat_out_valid0", int'(out_valid), 0);
        tick();
        check("lat_out_valid1", int'(out_valid), 1);
        check("lat_out_quot", int'(out_quot), 14);
        check("lat_out_dz", int'(out_dz), 0);
        check("lat_count0", int'(count), 0);
        tick();
        check("lat_drain", int'(out_valid), 0);

        // Zero divisor.
        in_valid = 1'b1; in_a = 8'd55; in_b = 8'd0;
        tick();
        in_valid = 1'b0;
        check("dz_head_b", int'(div_b), 0);
        tick();
        check("dz_out_quot", int'(out_quot), int'(ZR));
        check("dz_out_dz", int'(out_dz), 1);
        tick();

        // Backpressure: first result held, four pairs queued, extra push refused.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = bp_a[i]; in_b = bp_b[i];
            tick();
        end
        check("bp_held", int'(out_quot), 5);
        check("bp_count4", int'(count), 4);
        check("bp_in_ready", int'(in_ready), 0);
        in_a = 8'd99; in_b = 8'd9;
        tick();
        in_valid = 1'b0;
        check("bp_refused", int'(count), 4);
        check("bp_still_held", int'(out_quot), 5);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("bp_rel%0d", i), int'(out_quot), int'(rel[i]));
        end
        check("bp_empty", int'(count), 0);
        tick();
        check("bp_done", int'(out_valid), 0);

        // Streaming across several pointer wraps.
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_a = DW'(i * 13 + 5); in_b = DW'(i % 5 + 1);
            tick();
            check("stream_count_le1", int'(count <= 1), 1);
        end
        in_valid = 1'b0;
        repeat (2) tick();

        // Asynchronous reset mid-operation.
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'd20; in_b = 8'd4; tick();
        in_a = 8'd30; in_b = 8'd5; tick();
        in_a = 8'd40; in_b = 8'd8; tick();
        in_a = 8'd50; in_b = 8'd0; tick();
        in_valid = 1'b0;
        check("pre_rst_count", int'(count), 3);
        check("pre_rst_out_valid", int'(out_valid), 1);
        check("pre_rst_out_quot", int'(out_quot), 5);
        Rst = 1'b0;
        #1;
        check_reset_state("async");
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'd9; in_b = 8'd3;
        tick();
        in_valid = 1'b0;
        tick();
        check("post_rst_valid", int'(out_valid), 1);
        check("post_rst_quot", int'(out_quot), 3);
        check("post_rst_dz", int'(out_dz), 0);
        tick();
        check("post_rst_drain", int'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
